// File: rtl/tdm_mux_pkg.sv
// Shared constants, FSM state type and width helpers for the TDM channel multiplexer.
package tdm_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    localparam int unsigned DEF_N_CH  = 4;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DWELL = 4;

    typedef enum logic {
        ST_FIXED = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Pointer/counter width: never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/tdm_mux_scan_dwell.sv
// tdm_dwell_counter: DWELL-modulo counter with hold, sync clear, first-cycle and terminal-count strobes.
module tdm_dwell_counter
    import tdm_mux_pkg::*;
#(
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst,
    input  logic hold_i,
    input  logic clr_i,
    input  logic en_i,
    output logic first_o,
    output logic tc_o
);

    localparam int unsigned CNT_W = width_of(DWELL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign first_o = (cnt_q == '0);
    assign tc_o    = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = tc_o ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tdm_mux_scan.sv
// N-channel registered mux with fixed-select and time-division scan modes.
// Optional channel masking is built when TDM_MUX_SCAN_MASK_EN is defined.
module tdm_mux_scan
    import tdm_mux_pkg::*;
#(
    parameter  int unsigned N_CH  = DEF_N_CH,
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned DWELL = DEF_DWELL,
    localparam int unsigned SEL_W = width_of(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  hold,
    input  logic [N_CH*WIDTH-1:0] din,
`ifdef TDM_MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic [SEL_W-1:0]      ch_out,
    output logic                  frame_start
);

    localparam int unsigned SPAN = 1 << SEL_W;

    function automatic logic [SPAN-1:0] legal_map();
        logic [SPAN-1:0] r;
        for (int unsigned i = 0; i < SPAN; i++) r[i] = (i < N_CH);
        return r;
    endfunction

    localparam logic [SPAN-1:0] LEGAL = legal_map();

`ifdef TDM_MUX_SCAN_MASK_EN
    // Next enabled channel after p, wrapping; returns p if it is the only one.
    function automatic logic [SEL_W-1:0] next_set(input logic [SEL_W-1:0] p,
                                                  input logic [N_CH-1:0]  m);
        logic [SEL_W-1:0] r;
        logic             found;
        int unsigned      idx;
        r     = p;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = (32'(p) + i) % N_CH;
            if (!found && m[idx]) begin
                r     = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && m[i]) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               fs_q, fs_d;

    logic [SEL_W-1:0]   base, cur, first_ch;
    logic [SPAN-1:0]    mask_ext;
    logic               any, sel_ok;
    logic               cnt_first, cnt_tc;

    tdm_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (hold),
        .clr_i   (mode == MODE_FIXED),
        .en_i    ((mode == MODE_SCAN) && any),
        .first_o (cnt_first),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ch_d     = ch_q;
        fs_d     = 1'b0;

        base     = (state_q == ST_SCAN) ? ptr_q : '0;
`ifdef TDM_MUX_SCAN_MASK_EN
        mask_ext = SPAN'(ch_mask);
        any      = |ch_mask;
        cur      = mask_ext[base] ? base : next_set(base, ch_mask);
        first_ch = lowest_set(ch_mask);
`else
        mask_ext = '1;
        any      = 1'b1;
        cur      = base;
        first_ch = '0;
`endif
        sel_ok   = LEGAL[sel] && mask_ext[sel];

        if (!hold) begin
            if (mode == MODE_SCAN) begin
                state_d = ST_SCAN;
                if (any) begin
                    dout_d  = din[32'(cur)*WIDTH +: WIDTH];
                    valid_d = 1'b1;
                    ch_d    = cur;
                    // Frame marker rides with the first dwell cycle of the first enabled channel.
                    fs_d    = (cur == first_ch) && cnt_first;
                    if (cnt_tc) begin
`ifdef TDM_MUX_SCAN_MASK_EN
                        ptr_d = next_set(cur, ch_mask);
`else
                        ptr_d = (32'(cur) == N_CH - 1) ? '0 : cur + 1'b1;
`endif
                    end else begin
                        ptr_d = cur;
                    end
                end else begin
                    dout_d  = '0;
                    valid_d = 1'b0;
                    ch_d    = ptr_q;
                end
            end else begin
                state_d = ST_FIXED;
                ptr_d   = '0;
                ch_d    = sel;
                valid_d = sel_ok;
                dout_d  = sel_ok ? din[32'(sel)*WIDTH +: WIDTH] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FIXED;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            fs_q    <= fs_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign ch_out      = ch_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Self-checking bench for tdm_mux_scan: three configurations driven in parallel against a frame-position model.
module tb_tdm_mux_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, hold;
    logic [1:0]  sel_v;
    logic [31:0] din_v;
    logic [3:0]  mask_v;

    logic [7:0]  dout0, dout1, dout2;
    logic        v0, v1, v2;
    logic [1:0]  ch0, ch1;
    logic        ch2;
    logic        fs0, fs1, fs2;

    tdm_mux_scan #(.N_CH(4), .WIDTH(8), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel_v), .hold(hold), .din(din_v),
`ifdef TDM_MUX_SCAN_MASK_EN
        .ch_mask(mask_v),
`endif
        .dout(dout0), .dout_valid(v0), .ch_out(ch0), .frame_start(fs0)
    );

    tdm_mux_scan #(.N_CH(3), .WIDTH(8), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel_v), .hold(hold), .din(din_v[23:0]),
`ifdef TDM_MUX_SCAN_MASK_EN
        .ch_mask(mask_v[2:0]),
`endif
        .dout(dout1), .dout_valid(v1), .ch_out(ch1), .frame_start(fs1)
    );

    tdm_mux_scan #(.N_CH(1), .WIDTH(8), .DWELL(3)) u2 (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel_v[0]), .hold(hold), .din(din_v[7:0]),
`ifdef TDM_MUX_SCAN_MASK_EN
        .ch_mask(mask_v[0:0]),
`endif
        .dout(dout2), .dout_valid(v2), .ch_out(ch2), .frame_start(fs2)
    );

    localparam int NCH [3] = '{4, 3, 1};
    localparam int DW  [3] = '{4, 1, 3};
    localparam int SW  [3] = '{2, 2, 1};

    // Model: t counts unheld scan cycles since scan entry; channel and marker follow from it.
    int          t_m    [3];
    logic [7:0]  e_dout [3];
    logic        e_v    [3];
    int          e_ch   [3];
    logic        e_fs   [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            t_m[k] = 0; e_dout[k] = '0; e_v[k] = 1'b0; e_ch[k] = 0; e_fs[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int         n, d, s, idx;
        int         list [$];
        logic [3:0] m;
        n = NCH[k];
        d = DW[k];
        s = int'(sel_v) % (1 << SW[k]);
`ifdef TDM_MUX_SCAN_MASK_EN
        m = mask_v & 4'((1 << n) - 1);
`else
        m = 4'((1 << n) - 1);
`endif
        if (hold) begin
            e_fs[k] = 1'b0;
        end else if (!mode) begin
            t_m[k]    = 0;
            e_ch[k]   = s;
            e_v[k]    = (s < n) && m[s];
            e_dout[k] = e_v[k] ? din_v[s*8 +: 8] : 8'h00;
            e_fs[k]   = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) if (m[i]) list.push_back(i);
            if (list.size() == 0) begin
                e_dout[k] = 8'h00;
                e_v[k]    = 1'b0;
                e_ch[k]   = 0;
                e_fs[k]   = 1'b0;
            end else begin
                idx       = (t_m[k] / d) % list.size();
                e_ch[k]   = list[idx];
                e_fs[k]   = (t_m[k] % (list.size() * d)) == 0;
                e_dout[k] = din_v[e_ch[k]*8 +: 8];
                e_v[k]    = 1'b1;
                t_m[k]++;
            end
        end
    endtask

    task automatic check_all();
        check("u0_dout", dout0, e_dout[0]);
        check("u0_valid", v0, e_v[0]);
        check("u0_ch", ch0, e_ch[0]);
        check("u0_frame", fs0, e_fs[0]);
        check("u1_dout", dout1, e_dout[1]);
        check("u1_valid", v1, e_v[1]);
        check("u1_ch", ch1, e_ch[1]);
        check("u1_frame", fs1, e_fs[1]);
        check("u2_dout", dout2, e_dout[2]);
        check("u2_valid", v2, e_v[2]);
        check("u2_ch", ch2, e_ch[2]);
        check("u2_frame", fs2, e_fs[2]);
    endtask

    task automatic step();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0; sel_v = '0; din_v = '0; mask_v = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        din_v = 32'h44332211;
        sel_v = 2'd2;
        step();
        check("fixed_sel2_dout", dout0, 8'h33);
        sel_v = 2'd3;
        step();
        sel_v = 2'd1;
        step();

        mode = 1'b1;
        repeat (40) begin din_v = $urandom; step(); end

        mode = 1'b0;
        step();
        mode = 1'b1;
        repeat (10) begin din_v = $urandom; step(); end
        hold = 1'b1;
        repeat (5) begin din_v = $urandom; step(); end
        hold = 1'b0;
        repeat (24) begin din_v = $urandom; step(); end

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (20) begin din_v = $urandom; step(); end

`ifdef TDM_MUX_SCAN_MASK_EN
        mode = 1'b0; mask_v = 4'b1010;
        step();
        mode = 1'b1;
        repeat (12) begin din_v = $urandom; step(); end
        mode = 1'b0; mask_v = 4'b0000;
        step();
        mode = 1'b1;
        repeat (4) begin din_v = $urandom; step(); end
        mode = 1'b0; sel_v = 2'd0;
        step();
        mask_v = 4'hF;
        step();
`endif

        repeat (400) begin
            hold  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            sel_v = 2'($urandom);
            din_v = $urandom;
`ifdef TDM_MUX_SCAN_MASK_EN
            if (!mode && !hold && $urandom_range(0, 2) == 0) mask_v = 4'($urandom);
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
